coeff_byte_packer: RTL and testbench
====================================

// Module: coeff_byte_packer
// PURPOSE
//  Streaming ByteEncode_d front end: accepts one d-bit polynomial coefficient per beat and packs
//  coefficients LSB-first into a contiguous bit stream. Emits OUT_BYTES bytes per beat through a
//  bits2bytes instance. Sits between the compress stage and the byte sink; runtime d in 1..D_MAX.
// PARAMETERS
//  D_MAX      12   max coefficient width in bits; d_i range 1..D_MAX
//  OUT_BYTES  4    bytes per output beat; W = OUT_BYTES*8
//  N_COEFFS   256  coefficients per frame
// PORTS
//  clk_i          in   1                    clock; all logic rising-edge
//  rst_i          in   1                    synchronous, active-high reset
//  start_i        in   1                    frame start; samples d_i (honoured in IDLE only)
//  d_i            in   4                    coefficient width for the frame
//  coeff_i        in   D_MAX                coefficient; only bits [d-1:0] are packed
//  coeff_valid_i  in   1                    coefficient handshake valid
//  coeff_ready_o  out  1                    coefficient handshake ready
//  bytes_o        out  OUT_BYTES x 8        packed output, bytes_o[k] = stream bits [8k+7:8k]
//  out_valid_o    out  1                    output beat valid
//  out_ready_i    in   1                    output beat ready
//  out_last_o     out  1                    final beat of frame (qualified by out_valid_o)
//  busy_o         out  1                    high from accepted start_i until last beat accepted
//  err_o          out  1                    1-cycle pulse: start_i in IDLE with d_i==0 or d_i>D_MAX
//  range_err_o    out  1                    sticky, see CONFIGURATION
// BEHAVIOUR
//  Reset: state IDLE, accumulator/fill/coeff count cleared; all outputs 0, coeff_ready_o=0.
//  FSM: IDLE -> RUN on start_i with legal d (d latched, busy_o=1 next cycle); illegal d: stay IDLE,
//   err_o pulses. RUN -> FLUSH after N_COEFFS-th coefficient accepted. FLUSH -> IDLE when the
//   out_last_o beat is accepted. start_i outside IDLE ignored; d_i changes mid-frame ignored.
//  Accumulator ACC_W = W+D_MAX-1 bits, fill counter 0..ACC_W. Accepted coeff is ORed in at [fill +: d].
//  coeff_ready_o = (state==RUN) && (fill + d <= ACC_W) (fill as registered, not post-drain).
//  out_valid_o = (fill >= W) || (state==FLUSH && fill > 0). Beat = acc[W-1:0], combinational
//   from the registered accumulator (zero added latency beyond the register).
//  On out fire: acc >>= W, fill -= W (FLUSH partial beat: upper bits zero-padded, fill -> 0).
//  Simultaneous in/out fire in one cycle: shift first, then insert at (fill - W); net fill += d - W.
//  out_last_o = 1 on the beat after which no stream bits remain in FLUSH; if N_COEFFS*d is a
//   multiple of W, the last full beat carries out_last_o (no empty pad beat). RUN->FLUSH and
//   last-beat emission may fall in the same cycle.
//  Output holds bytes_o/out_valid_o stable while out_valid_o && !out_ready_i (AXI-style).
//  Input latency: coefficient to first byte visible <= 1 cycle after fill reaches W.
//  Reset mid-frame: everything discarded, IDLE next cycle, no out_last_o emitted.
// CONFIGURATION
//  COEFF_BYTE_PACKER_RANGE_CHECK_EN defined: on each accepted coeff with coeff_i >> d != 0,
//   range_err_o sets (sticky until rst_i or next accepted start_i); packing still masks to d bits.
//  Undefined: no check logic; range_err_o tied 0; masking unchanged.
// STRUCTURE
//  Package conv_pkg: D_W_BITS (=4) localparam, typedef enum logic [1:0] {PK_IDLE,PK_RUN,PK_FLUSH}.
//  Sub-module: bits2bytes #(.N_BYTES(OUT_BYTES)) maps acc[W-1:0] onto bytes_o.
//  All other logic (FSM, accumulator, counters) inline in this module.
// TESTING
//  1 d=1, coeffs 1,0,1,0... (256), out_ready_i=1 -> 8 beats, every byte 0x55, last on beat 8.
//  2 d=12, coeffs 0x123,0x456,0x789 -> first beat bytes_o = {0x89,0x45,0x61,0x23} ([3]..[0]).
//  3 d=0 and d=13 on start_i in IDLE -> err_o 1-cycle pulse each, busy_o stays 0.
//  4 d=11, out_ready_i toggled random 50% -> bytes_o stable while stalled; 88 beats match model.
//  5 N_COEFFS=3, d=5, coeffs 0x1F,0x00,0x1F -> one beat 0x00007C1F, out_last_o=1, then IDLE.
//  6 rst_i asserted mid-frame after 10 coeffs -> next cycle all outputs 0; new frame packs cleanly;
//    with RANGE_CHECK_EN, d=4 coeff 0x1F -> range_err_o=1 and packed nibble 0xF.

Source files
------------

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the coefficient byte packer.
//   D_W_BITS   : width of the runtime coefficient-width field d
//   pk_state_t : packer frame state (idle / accepting coefficients / draining)
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int D_W_BITS = 4;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_RUN,
        PK_FLUSH
    } pk_state_t;

endpackage

// File: rtl/coeff_byte_packer_bits2bytes.sv
// ----------------------------------------------------------------------------
// bits2bytes
// Slices a flat little-endian bit vector into bytes: bytes[k] = bits[8k+7:8k].
// Ports:
//   bits   in   N_BYTES*8   flat stream bits, bit 0 first
//   bytes  out  N_BYTES x 8 byte view of the same bits
// ----------------------------------------------------------------------------
module bits2bytes #(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES*8-1:0]   bits,
    output logic [N_BYTES-1:0][7:0] bytes
);

    for (genvar k = 0; k < N_BYTES; k++) begin : g_byte
        assign bytes[k] = bits[8*k +: 8];
    end

endmodule

// File: rtl/coeff_byte_packer.sv
// ----------------------------------------------------------------------------
// coeff_byte_packer
// Streaming ByteEncode_d front end. Accepts one d-bit coefficient per beat,
// packs coefficients LSB-first into a contiguous bit stream and emits
// OUT_BYTES bytes per output beat. d is chosen per frame (1..D_MAX).
//
// Optional feature macro: COEFF_BYTE_PACKER_RANGE_CHECK_EN
//   defined   : range_err_o sets (sticky) when an accepted coefficient has
//               bits set above bit d-1; cleared by rst_i or accepted start_i.
//   undefined : range_err_o tied 0.
//   Packing always masks the coefficient to d bits.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   start_i, d_i    frame start (IDLE only) and coefficient width for the frame
//   coeff_i         coefficient, bits [d-1:0] packed
//   coeff_valid_i / coeff_ready_o   input handshake
//   bytes_o         packed beat, bytes_o[k] = stream bits [8k+7:8k]
//   out_valid_o / out_ready_i       output handshake (held stable while stalled)
//   out_last_o      final beat of the frame
//   busy_o          frame in progress
//   err_o           one-cycle pulse on start_i with illegal d_i
//   range_err_o     sticky coefficient range error (see above)
// ----------------------------------------------------------------------------
module coeff_byte_packer
    import conv_pkg::*;
#(
    parameter int D_MAX     = 12,
    parameter int OUT_BYTES = 4,
    parameter int N_COEFFS  = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [D_W_BITS-1:0]       d_i,
    input  logic [D_MAX-1:0]          coeff_i,
    input  logic                      coeff_valid_i,
    output logic                      coeff_ready_o,
    output logic [OUT_BYTES-1:0][7:0] bytes_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      range_err_o
);

    localparam int W      = OUT_BYTES * 8;
    localparam int ACC_W  = W + D_MAX - 1;
    // Wide enough to hold fill + d without wrapping in the ready compare.
    localparam int FILL_W = $clog2(ACC_W + D_MAX + 1);
    localparam int CNT_W  = $clog2(N_COEFFS + 1);

    pk_state_t           state;
    logic [ACC_W-1:0]    acc;
    logic [FILL_W-1:0]   fill;
    logic [D_W_BITS-1:0] d_reg;
    logic [CNT_W-1:0]    cnt;
    logic                err_q;

    logic                start_ok;
    logic                in_fire;
    logic                out_fire;
    logic [ACC_W-1:0]    coeff_masked;
    logic [ACC_W-1:0]    acc_shift;
    logic [FILL_W-1:0]   fill_shift;
    logic [ACC_W-1:0]    acc_next;
    logic [FILL_W-1:0]   fill_next;

    assign start_ok = (d_i != '0) && (d_i <= D_W_BITS'(D_MAX));

    // Ready uses the registered fill so it never depends on out_ready_i.
    assign coeff_ready_o = (state == PK_RUN) &&
                           ((fill + FILL_W'(d_reg)) <= FILL_W'(ACC_W));
    assign out_valid_o   = (fill >= FILL_W'(W)) || ((state == PK_FLUSH) && (fill != '0));
    assign out_last_o    = out_valid_o && (state == PK_FLUSH) && (fill <= FILL_W'(W));
    assign busy_o        = (state != PK_IDLE);
    assign err_o         = err_q;

    assign in_fire  = coeff_valid_i && coeff_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // Bits above fill are always zero, so a shift-out leaves a clean
    // accumulator and a partial flush beat is zero-padded for free.
    always_comb begin
        coeff_masked = ACC_W'(coeff_i) & ((ACC_W'(1) << d_reg) - ACC_W'(1));
        acc_shift    = acc;
        fill_shift   = fill;
        if (out_fire) begin
            acc_shift  = acc >> W;
            fill_shift = (fill >= FILL_W'(W)) ? (fill - FILL_W'(W)) : '0;
        end
        acc_next  = acc_shift;
        fill_next = fill_shift;
        if (in_fire) begin
            acc_next  = acc_shift | (coeff_masked << fill_shift);
            fill_next = fill_shift + FILL_W'(d_reg);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= PK_IDLE;
            acc   <= '0;
            fill  <= '0;
            d_reg <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            acc   <= acc_next;
            fill  <= fill_next;
            case (state)
                PK_IDLE: begin
                    if (start_i) begin
                        if (start_ok) begin
                            state <= PK_RUN;
                            d_reg <= d_i;
                            cnt   <= '0;
                            acc   <= '0;
                            fill  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                PK_RUN: begin
                    if (in_fire) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_COEFFS - 1)) begin
                            state <= PK_FLUSH;
                        end
                    end
                end
                PK_FLUSH: begin
                    if ((out_fire && out_last_o) || (fill == '0)) begin
                        state <= PK_IDLE;
                    end
                end
                default: state <= PK_IDLE;
            endcase
        end
    end

`ifdef COEFF_BYTE_PACKER_RANGE_CHECK_EN
    logic range_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            range_q <= 1'b0;
        end else if ((state == PK_IDLE) && start_i && start_ok) begin
            range_q <= 1'b0;
        end else if (in_fire && ((coeff_i >> d_reg) != '0)) begin
            range_q <= 1'b1;
        end
    end

    assign range_err_o = range_q;
`else
    assign range_err_o = 1'b0;
`endif

    bits2bytes #(.N_BYTES(OUT_BYTES)) u_bits2bytes (
        .bits  (acc[W-1:0]),
        .bytes (bytes_o)
    );

endmodule

// File: tb/tb_coeff_byte_packer.sv
// ----------------------------------------------------------------------------
// tb_coeff_byte_packer
// Directed bench for coeff_byte_packer: start/d legality table, full-frame
// table checked against a bit-stream model, and hand sequences for the
// first-beat layout, a 3-coefficient partial flush, mid-frame reset and the
// optional range check (COEFF_BYTE_PACKER_RANGE_CHECK_EN).
// ----------------------------------------------------------------------------
module tb_coeff_byte_packer;

    localparam int D_MAX     = 12;
    localparam int OUT_BYTES = 4;
    localparam int N         = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic        start = 1'b0;
    logic [3:0]  d = '0;
    logic [11:0] coeff = '0;
    logic        cv = 1'b0;
    logic        cr;
    logic [3:0][7:0] bytes;
    logic        ov;
    logic        ordy = 1'b0;
    logic        last;
    logic        busy;
    logic        err;
    logic        rerr;

    // three-coefficient instance
    logic        start5 = 1'b0;
    logic [3:0]  d5 = '0;
    logic [11:0] coeff5 = '0;
    logic        cv5 = 1'b0;
    logic        cr5;
    logic [3:0][7:0] bytes5;
    logic        ov5;
    logic        ordy5 = 1'b0;
    logic        last5;
    logic        busy5;
    logic        err5;
    logic        rerr5;

    coeff_byte_packer #(.D_MAX(D_MAX), .OUT_BYTES(OUT_BYTES), .N_COEFFS(N)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .d_i(d), .coeff_i(coeff),
        .coeff_valid_i(cv), .coeff_ready_o(cr), .bytes_o(bytes), .out_valid_o(ov),
        .out_ready_i(ordy), .out_last_o(last), .busy_o(busy), .err_o(err),
        .range_err_o(rerr)
    );

    coeff_byte_packer #(.D_MAX(D_MAX), .OUT_BYTES(OUT_BYTES), .N_COEFFS(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start5), .d_i(d5), .coeff_i(coeff5),
        .coeff_valid_i(cv5), .coeff_ready_o(cr5), .bytes_o(bytes5), .out_valid_o(ov5),
        .out_ready_i(ordy5), .out_last_o(last5), .busy_o(busy5), .err_o(err5),
        .range_err_o(rerr5)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] coefs [0:N-1];

    typedef struct {
        logic [3:0] d;
        logic       exp_err;
        logic       exp_busy;
    } start_vec_t;

    typedef struct {
        int d;
        int pattern;     // 0: 1,0,1,0...  1: random 12-bit (garbage above d)
        bit rand_ready;
        bit rand_valid;
        int exp_beats;
    } frame_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_beat(input int b, input int dd);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            int k;
            k = b * 32 + j;
            if (k < N * dd) w[j] = coefs[k / dd][k % dd];
        end
        return w;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the coefficient is taken.
    task automatic feed(input logic [11:0] c);
        int n;
        n = 0;
        coeff = c;
        cv = 1'b1;
        #1;
        while (!cr && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("feed_ready", (n < 20), 1);
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int sent, beats, cyc;
        bit done, prev_hold;
        logic [31:0] prev_bytes;
        for (int i = 0; i < N; i++) begin
            if (v.pattern == 0) coefs[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
            else                coefs[i] = 12'($urandom_range(0, 4095));
        end
        @(negedge clk);
        start = 1'b1;
        d = 4'(v.d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("frame_busy", busy, 1);
        sent = 0; beats = 0; cyc = 0; done = 0; prev_hold = 0; prev_bytes = '0;
        while (!done && cyc < 4000) begin
            cv    = (sent < N) && (!v.rand_valid || ($urandom_range(0, 1) == 1));
            coeff = coefs[(sent < N) ? sent : 0];
            ordy  = !v.rand_ready || ($urandom_range(0, 1) == 1);
            d     = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 3) == 0);
            #1;
            if (prev_hold) begin
                check("hold_valid", ov, 1);
                check("hold_bytes", bytes, prev_bytes);
            end
            if (ov && ordy) begin
                check("beat_data", bytes, model_beat(beats, v.d));
                if (v.pattern == 0) check("beat_0x55", bytes, 32'h55555555);
                check("beat_last", last, (beats == v.exp_beats - 1));
                if (last) done = 1;
                beats++;
            end
            if (cv && cr) sent++;
            prev_hold  = ov && !ordy;
            prev_bytes = bytes;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        cv    = 1'b0;
        ordy  = 1'b0;
        #1;
        check("frame_done", done, 1);
        check("frame_beats", beats, v.exp_beats);
        check("frame_sent", sent, N);
        check("frame_idle_busy", busy, 0);
        check("frame_idle_valid", ov, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        start_vec_t svec[5];
        frame_vec_t fvec[4];

        svec[0] = '{4'd0,  1'b1, 1'b0};
        svec[1] = '{4'd13, 1'b1, 1'b0};
        svec[2] = '{4'd15, 1'b1, 1'b0};
        svec[3] = '{4'd1,  1'b0, 1'b1};
        svec[4] = '{4'd12, 1'b0, 1'b1};

        fvec[0] = '{1,  0, 1'b0, 1'b0, 8};
        fvec[1] = '{11, 1, 1'b1, 1'b0, 88};
        fvec[2] = '{12, 1, 1'b0, 1'b1, 96};
        fvec[3] = '{3,  1, 1'b1, 1'b1, 24};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cr, 0);
        check("rst_valid", ov, 0);
        check("rst_bytes", bytes, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_range", rerr, 0);
        check("rst3_valid", ov5, 0);
        check("rst3_busy", busy5, 0);
        rst = 1'b0;

        // start / d legality
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            d = svec[i].d;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check("start_err", err, svec[i].exp_err);
            check("start_busy", busy, svec[i].exp_busy);
            @(posedge clk);
            @(negedge clk);
            check("err_pulse_end", err, 0);
            pulse_reset();
        end

        // full frames against the bit-stream model
        for (int i = 0; i < 4; i++) begin
            run_frame(fvec[i]);
        end

        // first beat layout for d=12
        @(negedge clk);
        ordy = 1'b0;
        start = 1'b1;
        d = 4'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        feed(12'h123);
        feed(12'h456);
        check("d12_not_yet_valid", ov, 0);
        feed(12'h789);
        check("d12_valid", ov, 1);
        check("d12_bytes", bytes, 32'h89456123);
        check("d12_last", last, 0);
        pulse_reset();

        // three-coefficient frame with partial flush beat
        start5 = 1'b1;
        d5 = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coeff5 = (i == 1) ? 12'h000 : 12'h01F;
            cv5 = 1'b1;
            #1;
            check("n3_ready", cr5, 1);
            @(posedge clk);
            @(negedge clk);
        end
        cv5 = 1'b0;
        check("n3_valid", ov5, 1);
        check("n3_last", last5, 1);
        check("n3_bytes", bytes5, 32'h00007C1F);
        ordy5 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy5 = 1'b0;
        check("n3_idle_busy", busy5, 0);
        check("n3_idle_valid", ov5, 0);

        // reset mid-frame
        ordy = 1'b1;
        start = 1'b1;
        d = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) feed(12'($urandom_range(0, 4095)));
        pulse_reset();
        ordy = 1'b0;
        check("mid_rst_ready", cr, 0);
        check("mid_rst_valid", ov, 0);
        check("mid_rst_bytes", bytes, 0);
        check("mid_rst_last", last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_range", rerr, 0);

        // new frame after reset: out-of-range coefficient masked to d bits
        start = 1'b1;
        d = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("d4_range_clear", rerr, 0);
        feed(12'h01F);
        for (int i = 0; i < 7; i++) feed(12'h000);
        check("d4_valid", ov, 1);
        check("d4_bytes", bytes, 32'h0000000F);
`ifdef COEFF_BYTE_PACKER_RANGE_CHECK_EN
        check("d4_range_err", rerr, 1);
`else
        check("d4_range_err", rerr, 0);
`endif
        pulse_reset();

        run_frame('{7, 1, 1'b1, 1'b1, 56});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
